aurora_rx_nfc_buffer: RTL

Receive-side elastic buffer between one Aurora 64b66b lane's AXI RX stream (no ready) and the router-facing Q/Q_VALID/Q_BP port. It absorbs link-rate bursts in a FIFO and throttles the remote transmitter by issuing Aurora NFC XOFF/XON words as fill crosses watermarks. It runs on the lane's user clock (AURORA_CLK domain), one instance per channel.

---
 rtl/aurora_rx_nfc_buffer_pkg.sv | 8 +
 rtl/aurora_rx_fifo_fwft.sv | 61 ++++++
 rtl/aurora_rx_nfc_buffer.sv | 75 +++++++
 3 files changed

// File: rtl/aurora_rx_nfc_buffer_pkg.sv
// aurora_rx_nfc_buffer_pkg: shared NFC state encoding, word constants and lane data width.
package aurora_rx_nfc_buffer_pkg;
    localparam int DATA_W = 64;
    localparam int NFC_W = 16;
    localparam logic [NFC_W-1:0] XOFF_WORD_DEF = 16'hFFFF;
    localparam logic [NFC_W-1:0] XON_WORD_DEF = 16'h0000;
    typedef enum logic [1:0] {RUN, SEND_XOFF, PAUSED, SEND_XON} nfc_state_e;
endpackage

// File: rtl/aurora_rx_fifo_fwft.sv
// aurora_rx_fifo_fwft: single-clock first-word-fallthrough FIFO with a registered output word.
module aurora_rx_fifo_fwft
    import aurora_rx_nfc_buffer_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_bp,
    output logic [DATA_W-1:0] q,
    output logic              q_last,
    output logic              q_valid,
    output logic [AW:0]       fill
);
    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] fill_q, fill_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic last_q, last_d, valid_q, valid_d;
    logic pop, load, mem_ne;
    // fill includes the word held in the output register, so the array holds fill - valid words
    always_comb begin
        pop = valid_q & ~rd_bp;
        mem_ne = (fill_q - {{AW{1'b0}}, valid_q}) != '0;
        load = mem_ne & (~valid_q | pop) & ~flush;
        wptr_d = flush ? '0 : wptr_q + AW'(wr_en);
        rptr_d = flush ? '0 : rptr_q + AW'(load);
        fill_d = flush ? '0 : fill_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        valid_d = ~flush & (load | (valid_q & ~pop));
        {last_d, q_d} = load ? mem_q[rptr_q] : {last_q, q_q};
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= {wr_last, wr_data};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
            q_q <= '0;
            last_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
            q_q <= q_d;
            last_q <= last_d;
            valid_q <= valid_d;
        end
    end
    assign q = q_q;
    assign q_last = last_q;
    assign q_valid = valid_q;
    assign fill = fill_q;
endmodule

// File: rtl/aurora_rx_nfc_buffer.sv
// aurora_rx_nfc_buffer: Aurora RX elastic buffer that throttles the remote
// transmitter with NFC XOFF/XON as fill crosses the watermarks.
module aurora_rx_nfc_buffer
    import aurora_rx_nfc_buffer_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW = 9,
    parameter int HI_WM = 384,
    parameter int LO_WM = 128,
    parameter logic [NFC_W-1:0] XOFF_WORD = XOFF_WORD_DEF,
    parameter logic [NFC_W-1:0] XON_WORD = XON_WORD_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CH_UP,
    input  logic [DATA_W-1:0] RX_TDATA,
    input  logic              RX_TVALID,
    input  logic              RX_TLAST,
    output logic [DATA_W-1:0] Q,
    output logic              Q_LAST,
    output logic              Q_VALID,
    input  logic              Q_BP,
    output logic              NFC_TVALID,
    output logic [NFC_W-1:0]  NFC_TDATA,
    input  logic              NFC_TREADY,
    output logic [AW:0]       FILL,
    output logic              OVERFLOW
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] HI = (AW+1)'(HI_WM);
    localparam logic [AW:0] LO = (AW+1)'(LO_WM);
    nfc_state_e state_q, state_d;
    logic nfc_tvalid_q, nfc_tvalid_d, overflow_q, overflow_d;
    logic [NFC_W-1:0] nfc_tdata_q, nfc_tdata_d;
    logic rx_in, pop, full, wr_en;
    aurora_rx_fifo_fwft #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk(CLK), .rst_n(RST_N), .flush(~CH_UP), .wr_en(wr_en),
        .wr_data(RX_TDATA), .wr_last(RX_TLAST), .rd_bp(Q_BP),
        .q(Q), .q_last(Q_LAST), .q_valid(Q_VALID), .fill(FILL)
    );
    // a full FIFO still accepts a word when the router pops in the same cycle
    always_comb begin
        rx_in = RX_TVALID & CH_UP;
        pop = Q_VALID & ~Q_BP;
        full = FILL == FULL_LVL;
        wr_en = rx_in & (~full | pop);
        overflow_d = overflow_q | (rx_in & full & ~pop);
        state_d = state_q;
        case (state_q)
            RUN:       state_d = (FILL >= HI) ? SEND_XOFF : RUN;
            SEND_XOFF: state_d = NFC_TREADY ? PAUSED : SEND_XOFF;
            PAUSED:    state_d = (FILL <= LO) ? SEND_XON : PAUSED;
            default:   state_d = NFC_TREADY ? RUN : SEND_XON;
        endcase
        if (!CH_UP) state_d = RUN;
        nfc_tvalid_d = (state_d == SEND_XOFF) | (state_d == SEND_XON);
        nfc_tdata_d = (state_d == SEND_XOFF) ? XOFF_WORD : (state_d == SEND_XON) ? XON_WORD : nfc_tdata_q;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RUN;
            nfc_tvalid_q <= 1'b0;
            nfc_tdata_q <= XON_WORD;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nfc_tvalid_q <= nfc_tvalid_d;
            nfc_tdata_q <= nfc_tdata_d;
            overflow_q <= overflow_d;
        end
    end
    assign NFC_TVALID = nfc_tvalid_q;
    assign NFC_TDATA = nfc_tdata_q;
    assign OVERFLOW = overflow_q;
endmodule
